beat_gen: RTL
=============

Name: beat_gen

Overview:
- Beat (machine-cycle) generator for the hardwired controller.
- Produces the one-hot beat vector W[3:1] that the controller decodes.
- Consumes the controller's SHORT, LONG and STOP outputs to size each machine cycle and to halt.
- Implements the run/halt handshake with the console start button QD, including single-step.

Parameters:
- CNT_W, 16, width of the optional completed-cycle counter.

Ports:
- T3     input   1      clock; all state updates on its rising edge
- CLR    input   1      reset, synchronous, active-low (0 = reset)
- QD     input   1      console start button, level, already debounced and in the T3 domain
- SSTEP  input   1      single-step: halt after every machine cycle
- SHORT  input   1      from controller: current cycle ends after W1
- LONG   input   1      from controller: extend cycle to W3 when in W2
- STOP   input   1      from controller: halt at end of current cycle
- W      output  [3:1]  one-hot beat; 3'b000 while halted
- RUNNING output 1      1 while in RUN state
- CYC_DONE output 1     one-T3 pulse after each completed machine cycle
- CYC_CNT output [CNT_W-1:0] completed-cycle count (see Optional Feature)

Behaviour:
- Reset (CLR=0 at a T3 edge):
  - state=HALT, W=000, RUNNING=0, CYC_DONE=0, stop_pend=0, qd_q=0, CYC_CNT=0.
  - Reset wins over every other input.
  - Reset mid-cycle abandons the cycle without a CYC_DONE pulse.
- Start edge: start = QD & ~qd_q; qd_q <= QD every edge, in both states. Holding QD high yields exactly one start.
- HALT:
  - W=000. SHORT, LONG, STOP and SSTEP are ignored.
  - On start: next state=RUN, W=001, RUNNING=1, stop_pend=0.
- RUN, at each T3 edge with the current beat:
  - W1: if SHORT, end the cycle; else W <= 010. LONG is ignored in W1.
  - W2: if LONG, W <= 100; else end the cycle. SHORT is ignored in W2.
  - W3: always end the cycle.
- STOP handling:
  - stop_pend is set if STOP=1 at any edge of the cycle, and is sticky until the cycle ends.
  - halt_req = stop_pend | STOP | SSTEP, evaluated at the ending edge.
- End of cycle:
  - CYC_DONE <= 1 for exactly one T3 period; CYC_CNT increments.
  - If halt_req: state <= HALT, W <= 000, RUNNING <= 0.
  - Else: W <= 001 and the next cycle begins with no idle beat. stop_pend clears in both cases.
- CYC_DONE is 0 at all edges other than a cycle end.
- Start edge while in RUN is ignored and not queued.
- SSTEP changing mid-cycle takes effect only at the next cycle end.
- W is never anything other than 000, 001, 010 or 100. No illegal state is reachable; a corrupted encoding recovers to HALT/W=000 at the next edge.
- Latency: start edge to W1 is 1 T3. Beat lengths: short cycle = 1 T3, normal = 2, long = 3.

Optional Feature:
- Macro: BEAT_GEN_CYCLE_CNT_EN.
- Defined: CYC_CNT is a CNT_W-bit counter.
  - Increments on every cycle end, including a cycle that halts.
  - Wraps from all-ones to 0.
  - Cleared only by reset.
- Undefined: CYC_CNT is tied to 0 and the counter logic is absent. All other behaviour is identical.

Test Plan:
- Reset then idle, QD=0 for 5 edges -> W=000, RUNNING=0, CYC_DONE=0 throughout.
- QD 0->1 held 4 edges with SHORT=LONG=STOP=SSTEP=0 -> W sequence 001,010,001,010, CYC_DONE pulses after each W2; only one start is taken.
- Run with LONG=1 during W2 and SHORT=1 during the following W1 -> W sequence 001,010,100,001,001; CYC_DONE after W3 and after the short W1.
- STOP=1 only during W1 of a normal cycle -> cycle completes W2, then W=000, RUNNING=0 and one CYC_DONE pulse. A QD rising edge then restarts at W=001.
- SSTEP=1, three QD presses -> exactly three 2-beat cycles, W=000 between them; with the macro defined, CYC_CNT=3.
- CLR=0 asserted during W2 -> next edge W=000, RUNNING=0, no CYC_DONE. With the macro defined and CNT_W=2, four completed cycles wrap CYC_CNT 3->0.

Source files
------------

// File: rtl/beat_gen.sv
// beat_gen: machine-cycle beat generator producing one-hot W[3:1] with a
// run/halt handshake on the console start button QD, plus single-step.
// Ports: T3 clock, CLR sync active-low reset, QD start button, SSTEP
// single-step, SHORT/LONG/STOP cycle controls from the controller;
// W beat, RUNNING run flag, CYC_DONE end-of-cycle pulse, CYC_CNT count.
// Optional: BEAT_GEN_CYCLE_CNT_EN enables the CNT_W-bit cycle counter.
module beat_gen #(
  parameter int CNT_W = 16
) (
  input  logic             T3,
  input  logic             CLR,
  input  logic             QD,
  input  logic             SSTEP,
  input  logic             SHORT,
  input  logic             LONG,
  input  logic             STOP,
  output logic [3:1]       W,
  output logic             RUNNING,
  output logic             CYC_DONE,
  output logic [CNT_W-1:0] CYC_CNT
);

  typedef enum logic [1:0] {
    S_HALT = 2'd0,
    S_W1   = 2'd1,
    S_W2   = 2'd2,
    S_W3   = 2'd3
  } state_e;

  state_e state_q, state_d;
  logic   qd_q;
  logic   stop_pend_q, stop_pend_d;
  logic   cyc_done_q;
  logic   start;
  logic   halt_req;
  logic   cyc_end;

  // Only the rising edge of the level button starts a run.
  assign start    = QD & ~qd_q;
  assign halt_req = stop_pend_q | STOP | SSTEP;

  always_ff @(posedge T3) begin
    if (!CLR) begin
      state_q     <= S_HALT;
      qd_q        <= 1'b0;
      stop_pend_q <= 1'b0;
      cyc_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      qd_q        <= QD;
      stop_pend_q <= stop_pend_d;
      cyc_done_q  <= cyc_end;
    end
  end

  always_comb begin
    state_d     = S_HALT;
    stop_pend_d = 1'b0;
    cyc_end     = 1'b0;
    unique case (state_q)
      S_HALT: begin
        state_d = start ? S_W1 : S_HALT;
      end
      S_W1: begin
        if (SHORT) begin
          cyc_end = 1'b1;
        end else begin
          state_d     = S_W2;
          stop_pend_d = stop_pend_q | STOP;
        end
      end
      S_W2: begin
        if (LONG) begin
          state_d     = S_W3;
          stop_pend_d = stop_pend_q | STOP;
        end else begin
          cyc_end = 1'b1;
        end
      end
      S_W3: begin
        cyc_end = 1'b1;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
    // A completed cycle either halts or rolls straight into the next W1.
    if (cyc_end) begin
      state_d     = halt_req ? S_HALT : S_W1;
      stop_pend_d = 1'b0;
    end
  end

  always_comb begin
    W       = 3'b000;
    RUNNING = 1'b0;
    unique case (state_q)
      S_W1: begin
        W       = 3'b001;
        RUNNING = 1'b1;
      end
      S_W2: begin
        W       = 3'b010;
        RUNNING = 1'b1;
      end
      S_W3: begin
        W       = 3'b100;
        RUNNING = 1'b1;
      end
      default: begin
        W       = 3'b000;
        RUNNING = 1'b0;
      end
    endcase
  end

  assign CYC_DONE = cyc_done_q;

`ifdef BEAT_GEN_CYCLE_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cyc_end) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge T3) begin
    if (!CLR) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign CYC_CNT = cnt_q;
`else
  assign CYC_CNT = '0;
`endif

endmodule
